frame_writer: RTL and testbench

Pixel-stream ingest block on the write side of the LED panel frame buffer. It accepts a valid/ready RGB888 stream with start-of-frame and end-of-line markers and turns each accepted pixel into a single-word write to the triple buffer (`din`/`wraddr`/`wea`/`wr`). It also owns triple-buffer rotation: it tracks which buffer is being written, which holds the newest complete frame, and which is on display (`buffer_sel`). Display swaps happen only at the panel controller's frame boundary, so the panel never shows a torn frame.

---
 rtl/led_pkg.sv | 14 +
 rtl/buffer_rotator.sv | 33 +++
 rtl/frame_writer.sv | 94 +++++++++
 tb/tb_frame_writer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared frame geometry, pixel/buffer types and writer states for the LED panel frame buffer.
package led_pkg;
  localparam int FRAME_W = 128;
  localparam int FRAME_H = 32;
  localparam int ADDR_W = 12;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;
  typedef logic [1:0] buf_idx_t;
  typedef enum logic {IDLE, WRITE} fw_state_e;
  localparam logic [3:0] WEA_RGB = 4'b0111;
endpackage

// File: rtl/buffer_rotator.sv
// buffer_rotator: triple-buffer bookkeeping of displayed (D), pending (P) and written (W) buffers.
module buffer_rotator (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_sync,
  input  logic       frame_complete,
  output logic [1:0] buffer_sel,
  output logic [1:0] wr_buf
);
  import led_pkg::*;
  buf_idx_t disp, pend, wbuf, disp_sync;
  logic pend_valid, swap;
  // frame_sync is applied before completion, so completion sees the post-swap display index
  always_comb begin
    swap = frame_sync && pend_valid;
    disp_sync = swap ? pend : disp;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disp <= 2'd0;
      pend <= 2'd2;
      wbuf <= 2'd1;
      pend_valid <= 1'b0;
    end else begin
      disp <= disp_sync;
      pend <= frame_complete ? wbuf : pend;
      wbuf <= frame_complete ? 2'd3 - disp_sync - wbuf : wbuf;
      pend_valid <= frame_complete || (pend_valid && !swap);
    end
  end
  assign buffer_sel = disp;
  assign wr_buf = wbuf;
endmodule

// File: rtl/frame_writer.sv
// frame_writer: turns a framed RGB888 pixel stream into triple-buffer word writes and owns buffer rotation.
module frame_writer #(
  parameter int WIDTH = led_pkg::FRAME_W,
  parameter int HEIGHT = led_pkg::FRAME_H,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [23:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tuser,
  input  logic              s_tlast,
  input  logic              frame_sync,
  output logic [31:0]       din,
  output logic [ADDR_W-1:0] wraddr,
  output logic [3:0]        wea,
  output logic              wr,
  output logic [1:0]        wr_buf,
  output logic [1:0]        buffer_sel,
  output logic              frame_done,
  output logic              err
);
  import led_pkg::*;
  localparam logic [6:0] COL_MAX = 7'(WIDTH - 1);
  localparam logic [4:0] ROW_MAX = 5'(HEIGHT - 1);
  fw_state_e state, state_nx;
  logic [6:0] col, col_nx, wcol;
  logic [4:0] row, row_nx, wrow;
  logic accept, row_end, wr_nx, err_nx, done_nx;
  always_comb begin
    accept = s_tvalid && s_tready;
    row_end = s_tlast || col == COL_MAX;
    state_nx = state;
    col_nx = col;
    row_nx = row;
    wcol = col;
    wrow = row;
    wr_nx = 1'b0;
    err_nx = 1'b0;
    done_nx = 1'b0;
    if (accept && (s_tuser || state == WRITE)) begin
      wr_nx = 1'b1;
      if (s_tuser) begin
        wcol = 7'd0;
        wrow = 5'd0;
        col_nx = 7'd1;
        row_nx = 5'd0;
        state_nx = WRITE;
        err_nx = state == WRITE;
      end else begin
        err_nx = s_tlast != (col == COL_MAX);
        done_nx = row_end && row == ROW_MAX;
        col_nx = row_end ? 7'd0 : col + 7'd1;
        row_nx = !row_end ? row : (row == ROW_MAX ? 5'd0 : row + 5'd1);
        state_nx = done_nx ? IDLE : WRITE;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      col <= 7'd0;
      row <= 5'd0;
      s_tready <= 1'b0;
      din <= 32'd0;
      wraddr <= '0;
      wea <= 4'd0;
      wr <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      col <= col_nx;
      row <= row_nx;
      s_tready <= 1'b1;
      din <= wr_nx ? {8'h00, s_tdata} : din;
      wraddr <= wr_nx ? ADDR_W'({wrow, wcol}) : wraddr;
      wea <= wr_nx ? WEA_RGB : 4'd0;
      wr <= wr_nx;
      frame_done <= done_nx;
      err <= err_nx;
    end
  end
  // completion is fed from the registered pulse so the final write still carries the old wr_buf
  buffer_rotator u_rot (
    .clk           (clk),
    .resetn        (resetn),
    .frame_sync    (frame_sync),
    .frame_complete(frame_done),
    .buffer_sel    (buffer_sel),
    .wr_buf        (wr_buf)
  );
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: scoreboard bench for frame_writer; stimulus pushes expected writes, a monitor pops them.
module tb_frame_writer;
  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  we;
    logic        dn;
    logic        er;
    logic [1:0]  wb;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [23:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0, frame_sync = 1'b0;
  logic s_tready, wr, frame_done, err;
  logic [31:0] din;
  logic [11:0] wraddr;
  logic [3:0] wea;
  logic [1:0] wr_buf, buffer_sel;
  int compared = 0, mismatched = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  frame_writer dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast), .frame_sync(frame_sync), .din(din), .wraddr(wraddr),
    .wea(wea), .wr(wr), .wr_buf(wr_buf), .buffer_sel(buffer_sel), .frame_done(frame_done), .err(err)
  );
  always @(negedge clk) begin
    if (resetn) begin
      if (wr) begin
        exp_t e, g;
        g = '{wraddr, din, wea, frame_done, err, wr_buf};
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_wr: got addr=%h din=%h with nothing expected", wraddr, din);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            mismatched++;
            $display("FAIL write: got addr=%h din=%h wea=%b done=%b err=%b wr_buf=%0d, want addr=%h din=%h wea=%b done=%b err=%b wr_buf=%0d",
              g.a, g.d, g.we, g.dn, g.er, g.wb, e.a, e.d, e.we, e.dn, e.er, e.wb);
          end
        end
      end else if (frame_done || err) begin
        compared++;
        mismatched++;
        $display("FAIL pulse_without_wr: got done=%b err=%b, want 0 0", frame_done, err);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask
  task automatic px(input logic [23:0] d, input logic u, input logic l, input logic [11:0] a,
                    input logic er, input logic dn, input logic [1:0] wb);
    @(negedge clk);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    exp_q.push_back('{a, {8'h00, d}, 4'b0111, dn, er, wb});
  endtask
  task automatic stray(input logic l);
    @(negedge clk);
    s_tdata = 24'hDEAD00; s_tuser = 1'b0; s_tlast = l; s_tvalid = 1'b1;
  endtask
  task automatic pixels(input int lo, input int hi, input logic [1:0] wb, input logic first_err, input int miss_last);
    for (int i = lo; i <= hi; i++) begin
      logic l;
      l = (i % 128 == 127) && i != miss_last;
      px(24'(i * 257), i == 0, l, 12'(i), (i == lo && first_err) || i == miss_last, i == 4095, wb);
    end
  endtask
  task automatic drain();
    @(negedge clk);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask
  task automatic chk_reset();
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_din", din, 0);
    chk("rst_wraddr", 32'(wraddr), 0);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_buffer_sel", 32'(buffer_sel), 0);
    chk("rst_wr_buf", 32'(wr_buf), 1);
    chk("rst_done_err", {30'd0, frame_done, err}, 0);
  endtask
  task automatic sync_pulse();
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    @(negedge clk);
    chk("tready_after_release", 32'(s_tready), 1);
    stray(1'b0); stray(1'b1); stray(1'b0);
    pixels(0, 4095, 2'd1, 1'b0, -1);
    drain();
    chk("f1_wr_buf", 32'(wr_buf), 2);
    chk("f1_buffer_sel", 32'(buffer_sel), 0);
    sync_pulse();
    chk("sync1_buffer_sel", 32'(buffer_sel), 1);
    pixels(0, 4095, 2'd2, 1'b0, -1);
    drain();
    chk("f2_wr_buf", 32'(wr_buf), 0);
    sync_pulse();
    chk("sync2_buffer_sel", 32'(buffer_sel), 2);
    chk("sync2_wr_buf", 32'(wr_buf), 0);
    pixels(0, 199, 2'd0, 1'b0, -1);
    drain();
    @(negedge clk); resetn = 1'b0;
    @(negedge clk);
    chk_reset();
    resetn = 1'b1;
    stray(1'b0); stray(1'b0); stray(1'b1);
    pixels(0, 4095, 2'd1, 1'b0, -1);
    drain();
    pixels(0, 4095, 2'd2, 1'b0, -1);
    drain();
    chk("drop_buffer_sel", 32'(buffer_sel), 0);
    chk("drop_wr_buf", 32'(wr_buf), 1);
    pixels(0, 4095, 2'd1, 1'b0, -1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("simul_buffer_sel", 32'(buffer_sel), 2);
    chk("simul_wr_buf", 32'(wr_buf), 0);
    drain();
    pixels(0, 299, 2'd0, 1'b0, -1);
    pixels(0, 4095, 2'd0, 1'b1, -1);
    drain();
    chk("abort_wr_buf", 32'(wr_buf), 1);
    chk("abort_buffer_sel", 32'(buffer_sel), 2);
    pixels(0, 3 * 128 + 4, 2'd1, 1'b0, 127);
    px(24'h00ABCD, 1'b0, 1'b1, 12'd389, 1'b1, 1'b0, 2'd1);
    pixels(512, 4095, 2'd1, 1'b0, -1);
    drain();
    chk("early_wr_buf", 32'(wr_buf), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
